// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared state encoding and width helpers for the isqrt_hypot engine.
// Widths are functions of W so every instance derives its own from its parameter.
package isqrt_pkg;

    localparam int DEF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        ROUND,
        DONE
    } state_e;

    function automatic int rw_of(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int qw_of(input int w);
        return w + 1;
    endfunction

    function automatic int rmw_of(input int w);
        return w + 2;
    endfunction

    function automatic int cnt_w_of(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring digit-by-digit square-root iteration.
// Consumes two radicand bits and retires one root bit.
module isqrt_step #(
    parameter int W = 16
) (
    input  logic [W+1:0] rem_i,
    input  logic [W:0]   root_i,
    input  logic [1:0]   bits_i,
    output logic [W+1:0] rem_o,
    output logic [W:0]   root_o
);

    logic [W+3:0] r;
    logic [W+3:0] t;
    logic         ge;

    always_comb begin
        r      = {rem_i, bits_i};
        t      = {1'b0, root_i, 2'b01};
        ge     = r >= t;
        // rem <= 2*root bounds both branches to W+2 bits
        rem_o  = (W+2)'(ge ? r - t : r);
        root_o = (W+1)'({root_i, ge});
    end

endmodule

// File: rtl/isqrt_hypot.sv
// isqrt_hypot: iterative floor(sqrt(A)) or floor(sqrt(A*A+B*B)) behind a Start/Done handshake.
// Define ISQRT_ROUND_EN to add a ROUND state that rounds Q to nearest (Rem stays unrounded).
module isqrt_hypot
    import isqrt_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Mode,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [W:0]   Q,
    output logic [W+1:0] Rem
);

    localparam int RW    = rw_of(W);
    localparam int QW    = qw_of(W);
    localparam int RMW   = rmw_of(W);
    localparam int CNT_W = cnt_w_of(W);

    state_e           state_q, state_d;
    logic [RW-1:0]    rad_q, rad_d;
    logic [RMW-1:0]   rem_q, rem_d;
    logic [QW-1:0]    root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [QW-1:0]    q_out_q, q_out_d;
    logic [RMW-1:0]   rem_out_q, rem_out_d;
    logic [RMW-1:0]   step_rem;
    logic [QW-1:0]    step_root;

    isqrt_step #(.W(W)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[RW-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            q_out_q   <= '0;
            rem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            q_out_q   <= q_out_d;
            rem_out_q <= rem_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = Start ? LOAD : IDLE;
            LOAD:    state_d = ITER;
`ifdef ISQRT_ROUND_EN
            ITER:    state_d = (cnt_q == '0) ? ROUND : ITER;
            ROUND:   state_d = DONE;
`else
            ITER:    state_d = (cnt_q == '0) ? DONE : ITER;
`endif
            DONE:    state_d = Start ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == ITER) || (state_q == ROUND);
        Done = state_q == DONE;
        Q    = q_out_q;
        Rem  = rem_out_q;
    end

    always_comb begin
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        q_out_d   = q_out_q;
        rem_out_d = rem_out_q;
        if (state_q == LOAD) begin
            rad_d  = Mode ? RW'(A) * RW'(A) + RW'(B) * RW'(B) : RW'(A);
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(W);
        end else if (state_q == ITER) begin
            // radicand shifts left so the next bit pair is always at the top
            rad_d  = rad_q << 2;
            rem_d  = step_rem;
            root_d = step_root;
            cnt_d  = cnt_q - CNT_W'(1);
        end
`ifdef ISQRT_ROUND_EN
        if (state_q == ROUND) begin
            q_out_d   = root_q + QW'(rem_q > RMW'(root_q));
            rem_out_d = rem_q;
        end
`else
        if (state_q == ITER && cnt_q == '0) begin
            q_out_d   = step_root;
            rem_out_d = step_rem;
        end
`endif
    end

endmodule
